// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, bin-count derivation and saturation helper
package fft_pkg;
  typedef enum logic [2:0] {IDLE, FILL, DRAIN, DONE, FLUSH, DROP} state_t;
  function automatic int nbins(input int aw);
    return 1 << aw;
  endfunction
  function automatic logic [63:0] sat_u(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : (64'(1) << w) - 64'(1);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/fft_magsq.sv
// fft_magsq: 2-stage pipelined re^2+im^2 with address sideband and saturation
module fft_magsq
  import fft_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic signed [IN_W-1:0]   in_re,
  input  logic signed [IN_W-1:0]   in_im,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy
);
  localparam int SUM_W = 2*IN_W;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [SUM_W-1:0]  rr_q, rr_d, ii_q, ii_d, sum;
  logic [DATA_W-1:0] d2_q, d2_d;
  // squares are non-negative and each at most 2**(2*IN_W-2), so the full-width sum cannot overflow
  always_comb begin
    v1_d = in_valid;
    a1_d = in_addr;
    rr_d = in_re * in_re;
    ii_d = in_im * in_im;
    sum  = rr_q + ii_q;
    v2_d = v1_q;
    a2_d = a1_q;
    d2_d = DATA_W'(sat_u(64'(sum), DATA_W));
  end
  // pipeline registers; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a1_q <= '0;
      a2_q <= '0;
      rr_q <= '0;
      ii_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      a1_q <= a1_d;
      a2_q <= a2_d;
      rr_q <= rr_d;
      ii_q <= ii_d;
      d2_q <= d2_d;
    end
  end
  assign out_valid = v2_q;
  assign out_addr  = a2_q;
  assign out_data  = d2_q;
  assign busy      = v1_q | v2_q;
endmodule

// File: rtl/fft_ramwriter.sv
// fft_ramwriter: frames FFT beats into the bin RAM as saturated |X|^2 and signals completion
module fft_ramwriter
  import fft_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sink_valid,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic signed [IN_W-1:0] sink_real,
  input  logic signed [IN_W-1:0] sink_imag,
  output logic                   sink_ready,
  input  logic                   rd_busy,
  output logic                   wren,
  output logic [ADDR_W-1:0]      wraddress,
  output logic [DATA_W-1:0]      data,
  output logic                   fftdone,
  output logic                   frame_err,
  output logic [7:0]             drop_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(nbins(ADDR_W) - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, idx;
  logic              err_q, err_d, rdy_en_q, rdy_en_d, acc, wr, last, mag_busy;
  logic [7:0]        drop_q, drop_d;
  assign sink_ready = rdy_en_q & ~reset & (state_q inside {IDLE, FILL, FLUSH, DROP});
  // frame FSM: a sop beat always restarts at bin 0; the bin reached decides how the frame ends
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    drop_d   = drop_q;
    rdy_en_d = 1'b1;
    wr       = 1'b0;
    acc      = sink_valid & sink_ready;
    idx      = sink_sop ? '0 : cnt_q;
    last     = idx == LAST;
    case (state_q)
      IDLE: if (acc && sink_sop) begin
        if (rd_busy) begin
          state_d = sink_eop ? IDLE : DROP;
          drop_d  = drop_q + 8'(drop_q != 8'hff);
        end else wr = 1'b1;
      end
      FILL: if (acc) begin
        wr    = 1'b1;
        err_d = err_q | sink_sop;
      end
      DRAIN:   state_d = mag_busy ? DRAIN : DONE;
      DONE:    state_d = IDLE;
      default: if (acc && sink_eop) state_d = IDLE;
    endcase
    if (wr) begin
      cnt_d   = last ? '0 : idx + 1'b1;
      state_d = sink_eop ? (last ? DRAIN : IDLE) : (last ? FLUSH : FILL);
      err_d   = err_d | (sink_eop ^ last);
    end
  end
  // state, counter and bookkeeping registers; ready stays low for one cycle after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      rdy_en_q <= rdy_en_d;
    end
  end
  fft_magsq #(.IN_W(IN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_magsq (
    .clk      (clk),
    .reset    (reset),
    .in_valid (wr),
    .in_addr  (idx),
    .in_re    (sink_real),
    .in_im    (sink_imag),
    .out_valid(wren),
    .out_addr (wraddress),
    .out_data (data),
    .busy     (mag_busy)
  );
  assign fftdone   = state_q == DONE;
  assign frame_err = err_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_fft_ramwriter.sv
// tb_fft_ramwriter: directed frames with a write scoreboard and RAM model
module tb_fft_ramwriter;
  logic clk = 1'b0, reset = 1'b1, sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0, rd_busy = 1'b0;
  logic signed [15:0] sink_real = '0, sink_imag = '0;
  logic sink_ready, wren, fftdone, frame_err;
  logic [9:0] wraddress;
  logic [31:0] data;
  logic [7:0] drop_cnt;
  typedef struct {logic [9:0] a; logic [31:0] d; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] ram [1024];
  int checks = 0, errors = 0, cyc = 0, last_wr = -100, wr_cnt = 0, done_cnt = 0, stalls = 0;

  fft_ramwriter dut (
    .clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_ready(sink_ready), .rd_busy(rd_busy),
    .wren(wren), .wraddress(wraddress), .data(data), .fftdone(fftdone), .frame_err(frame_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input int re, input int im);
    longint s;
    s = longint'(re) * re + longint'(im) * im;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
  endfunction

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      ram[wraddress] = data;
      wr_cnt++;
      last_wr = cyc;
      if (q.size() == 0) chk("unexpected_wren", 1, 0);
      else begin
        e = q.pop_front();
        chk("wr_addr", 64'(wraddress), 64'(e.a));
        chk("wr_data", 64'(data), 64'(e.d));
        chk("wr_cycle", 64'(cyc), 64'(e.c));
      end
    end
    if (fftdone === 1'b1) begin
      done_cnt++;
      chk("done_gap", 64'(cyc), 64'(last_wr + 2));
    end
  end

  task automatic beat(input int re, input int im, input logic sop, input logic eop, input logic wr, input int a);
    int n = 0;
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    sink_real = 16'(re); sink_imag = 16'(im);
    while (!sink_ready && n < 20) begin @(posedge clk); #1; n++; end
    stalls += n;
    if (n == 20) chk("ready_timeout", 0, 1);
    if (wr) q.push_back('{10'(a), mag(re, im), cyc + 2});
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int exp);
    int n = 0;
    while (done_cnt != exp && n < 50) begin @(posedge clk); #1; n++; end
    idle(4);
    chk("fftdone_count", 64'(done_cnt), 64'(exp));
    chk("queue_empty", 64'(q.size()), 0);
  endtask

  initial begin
    int r, m;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, m, d0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wren", 64'(wren), 0);
    chk("rst_fftdone", 64'(fftdone), 0);
    chk("rst_frame_err", 64'(frame_err), 0);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    chk("rst_wraddress", 64'(wraddress), 0);
    chk("rst_data", 64'(data), 0);
    chk("rst_ready", 64'(sink_ready), 0);
    reset = 1'b0;
    chk("ready_after_rst", 64'(sink_ready), 0);
    idle(1);
    chk("ready_up", 64'(sink_ready), 1);
    // 1: full frame, one non-zero bin
    wr_cnt = 0;
    for (int i = 0; i < 1024; i++)
      beat(i == 37 ? 300 : 0, i == 37 ? 400 : 0, i == 0, i == 1023, 1'b1, i);
    wait_done(1);
    chk("t1_ram37", 64'(ram[37]), 250000);
    chk("t1_ram0", 64'(ram[0]), 0);
    chk("t1_ram1023", 64'(ram[1023]), 0);
    chk("t1_wren_count", 64'(wr_cnt), 1024);
    // 2: gapped valid, most negative input on bin 5
    for (int i = 0; i < 1024; i++) begin
      r = int'($urandom_range(2000)) - 1000;
      m = int'($urandom_range(2000)) - 1000;
      if (i == 5) begin r = -32768; m = -32768; end
      beat(r, m, i == 0, i == 1023, 1'b1, i);
      idle(2);
    end
    wait_done(2);
    chk("t2_ram5", 64'(ram[5]), 64'h8000_0000);
    // 4: frame dropped while readers are busy, then a normal frame
    rd_busy = 1'b1; stalls = 0; wr_cnt = 0;
    for (int i = 0; i < 1024; i++) beat(7, 7, i == 0, i == 1023, 1'b0, i);
    idle(4);
    chk("t4_no_wren", 64'(wr_cnt), 0);
    chk("t4_drop_cnt", 64'(drop_cnt), 1);
    chk("t4_no_stall", 64'(stalls), 0);
    chk("t4_no_done", 64'(done_cnt), 2);
    rd_busy = 1'b0;
    for (int i = 0; i < 1024; i++) beat(i % 9, 2, i == 0, i == 1023, 1'b1, i);
    wait_done(3);
    chk("t4_ram8", 64'(ram[8]), 68);
    // 3: short frame then clean frame
    chk("t3_err_before", 64'(frame_err), 0);
    for (int i = 0; i <= 500; i++) beat(i % 5, 1, i == 0, i == 500, 1'b1, i);
    idle(8);
    chk("t3_err", 64'(frame_err), 1);
    chk("t3_no_done", 64'(done_cnt), 3);
    for (int i = 0; i < 1024; i++) beat(3, i % 4, i == 0, i == 1023, 1'b1, i);
    wait_done(4);
    chk("t3_err_sticky", 64'(frame_err), 1);
    // 6: reset mid-frame abandons the frame and the pipeline
    for (int i = 0; i < 600; i++) beat(i % 7, 1, i == 0, 1'b0, 1'b1, i);
    reset = 1'b1; sink_valid = 1'b1; sink_real = 16'sd5; sink_imag = 16'sd5;
    #1;
    chk("t6_ready_in_rst", 64'(sink_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0; sink_valid = 1'b0;
    chk("t6_pending", 64'(q.size()), 1);
    q.delete();
    for (int i = 0; i < 6; i++) begin
      chk("t6_wren_off", 64'(wren), 0);
      idle(1);
    end
    chk("t6_no_done", 64'(done_cnt), 4);
    chk("t6_err_clr", 64'(frame_err), 0);
    chk("t6_drop_clr", 64'(drop_cnt), 0);
    for (int i = 0; i < 1024; i++) beat(i % 11, i % 13, i == 0, i == 1023, 1'b1, i);
    wait_done(5);
    chk("t6_err_clean", 64'(frame_err), 0);
    // 5: sop re-asserted mid-frame restarts at bin 0
    for (int i = 0; i < 200; i++) beat(1, 1, i == 0, 1'b0, 1'b1, i);
    for (int i = 0; i < 1024; i++) beat(i % 50, 3, i == 0, i == 1023, 1'b1, i);
    wait_done(6);
    chk("t5_err", 64'(frame_err), 1);
    chk("t5_ram10", 64'(ram[10]), 109);
    chk("t5_ram150", 64'(ram[150]), 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
